// File: rtl/iob_delay_dev.sv
// Timed IO bus slave: DATAO word is held busy DELAY cycles, then posted.
// Ports: clk/reset, bus strobes+select in; pi_req, iob_read, dev_data/strobe out. Option: IOB_OVERRUN_EN.
module iob_delay_dev #(
  parameter logic [6:0] DEVICE = 7'o024,
  parameter int         DELAY  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iob_poweron,
  input  logic        iob_reset,
  input  logic        datao_clear,
  input  logic        datao_set,
  input  logic        cono_clear,
  input  logic        cono_set,
  input  logic        iob_fm_datai,
  input  logic        iob_fm_status,
  input  logic [3:9]  ios,
  input  logic [0:35] iob_write,
  output logic [1:7]  pi_req,
  output logic [0:35] iob_read,
  output logic [0:35] dev_data,
  output logic        dev_strobe
);

  localparam logic [15:0] DLY = 16'(DELAY);

  logic        sel;
  logic [0:35] data_q, data_n;
  logic [2:0]  pia, pia_n;
  logic        busy, busy_n;
  logic        done, done_n;
  logic [15:0] timer, timer_n;
  logic [0:35] dev_data_n;
  logic        strobe_n;
  logic [1:7]  pi_req_n;
  logic        ovf, ovf_n;

  logic dc_q, ds_q, cc_q, cs_q, di_q, ir_q;
  logic dc_rise, ds_rise, cc_rise, cs_rise, di_fall;
  logic clr;

  assign sel     = (ios == DEVICE);
  assign dc_rise = sel & datao_clear & ~dc_q;
  assign ds_rise = sel & datao_set & ~ds_q;
  assign cc_rise = sel & cono_clear & ~cc_q;
  assign cs_rise = sel & cono_set & ~cs_q;
  assign di_fall = sel & ~iob_fm_datai & di_q;
  assign clr     = ~iob_poweron | (iob_reset & ~ir_q);

  always_comb begin
    data_n     = data_q;
    pia_n      = pia;
    busy_n     = busy;
    done_n     = done;
    timer_n    = timer;
    dev_data_n = dev_data;
    strobe_n   = 1'b0;
    ovf_n      = ovf;
    if (cc_rise) begin
      pia_n   = '0;
      done_n  = 1'b0;
      busy_n  = 1'b0;
      timer_n = '0;
      ovf_n   = 1'b0;
    end
    if (dc_rise) begin
      data_n = '0;
      done_n = 1'b0;
    end
    if (di_fall)
      done_n = 1'b0;
    if (cs_rise) begin
      pia_n = pia_n | iob_write[33:35];
      if (iob_write[32]) done_n = 1'b1;
      if (iob_write[31]) done_n = 1'b0;
    end
    if (ds_rise) begin
      if (!busy_n) begin
        data_n  = data_n | iob_write;
        busy_n  = 1'b1;
        timer_n = DLY;
      end else begin
`ifdef IOB_OVERRUN_EN
        ovf_n = 1'b1;
`endif
      end
    end
    // A cono_clear abandons the transfer, so the timer only runs
    // when the transfer survived this cycle.
    if (busy && !cc_rise) begin
      if (timer == 16'd1) begin
        busy_n     = 1'b0;
        done_n     = 1'b1;
        timer_n    = '0;
        dev_data_n = data_n;
        strobe_n   = 1'b1;
      end else begin
        timer_n = timer - 16'd1;
      end
    end
    // Registered from next state so the request tracks done/ovf.
    for (int n = 1; n <= 7; n++)
      pi_req_n[n] = (done_n | ovf_n) & (pia_n == 3'(n));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q <= 1'b0;
    end else begin
      ir_q <= iob_reset;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      pia        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timer      <= '0;
      dev_data   <= '0;
      dev_strobe <= 1'b0;
      pi_req     <= '0;
      dc_q       <= 1'b0;
      ds_q       <= 1'b0;
      cc_q       <= 1'b0;
      cs_q       <= 1'b0;
      di_q       <= 1'b0;
    end else if (clr) begin
      data_q     <= '0;
      pia        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timer      <= '0;
      dev_data   <= '0;
      dev_strobe <= 1'b0;
      pi_req     <= '0;
      dc_q       <= 1'b0;
      ds_q       <= 1'b0;
      cc_q       <= 1'b0;
      cs_q       <= 1'b0;
      di_q       <= 1'b0;
    end else begin
      data_q     <= data_n;
      pia        <= pia_n;
      busy       <= busy_n;
      done       <= done_n;
      timer      <= timer_n;
      dev_data   <= dev_data_n;
      dev_strobe <= strobe_n;
      pi_req     <= pi_req_n;
      dc_q       <= datao_clear;
      ds_q       <= datao_set;
      cc_q       <= cono_clear;
      cs_q       <= cono_set;
      di_q       <= iob_fm_datai;
    end
  end

`ifdef IOB_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf <= 1'b0;
    else if (clr)
      ovf <= 1'b0;
    else
      ovf <= ovf_n;
  end
`else
  assign ovf = 1'b0;
`endif

  logic [0:35] status;

  always_comb begin
    status        = '0;
    status[30]    = ovf;
    status[31]    = busy;
    status[32]    = done;
    status[33:35] = pia;
    iob_read      = '0;
    if (sel & iob_fm_datai)
      iob_read = iob_read | data_q;
    if (sel & iob_fm_status)
      iob_read = iob_read | status;
  end

endmodule
